// File: rtl/bpc_fifo_arbiter.sv
// Round-robin burst arbiter sharing one encoder FIFO write port among NUM_REQ lanes.
// Optional: define BPC_ARB_THROTTLE_EN to hold off new grants while the FIFO is at/above half-full.
//
// state   | meaning
// S_IDLE  | no lane locked; scanning req_i from r_rr_ptr for the next owner
// S_GRANT | r_owner locked; its beats forwarded to the FIFO until last/cap/withdraw
module bpc_fifo_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BITWIDTH  = 64,
    parameter int MAX_BURST = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            last_i,
    input  logic [NUM_REQ*BITWIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [BITWIDTH-1:0]           fifo_data_o,
    output logic                          fifo_wr_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_threshold_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    owner_o
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [OW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;

    logic            w_found;
    logic [OW-1:0]   w_win;
    logic            w_owner_req;
    logic            w_accept;
    logic            w_release;
    logic            w_launch_ok;
    logic [OW-1:0]   w_owner_inc;

`ifdef BPC_ARB_THROTTLE_EN
    assign w_launch_ok = ~fifo_threshold_i;
`else
    logic w_unused_threshold;
    assign w_unused_threshold = fifo_threshold_i;
    assign w_launch_ok        = 1'b1;
`endif

    // Scan downwards so the candidate closest to r_rr_ptr is written last and wins.
    always_comb begin
        int            idx;
        logic [OW-1:0] l_idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        l_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            l_idx = OW'(idx);
            if (req_i[l_idx]) begin
                w_found = 1'b1;
                w_win   = l_idx;
            end
        end
    end

    assign w_owner_req = req_i[r_owner];
    assign w_accept    = (r_state == S_GRANT) && w_owner_req && !fifo_full_i;
    assign w_release   = (r_state == S_GRANT) &&
                         (!w_owner_req ||
                          (w_accept && (last_i[r_owner] ||
                                        ((r_beat_cnt + CW'(1)) == CW'(MAX_BURST)))));
    assign w_owner_inc = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

    assign fifo_wr_o   = w_accept;
    assign gnt_o       = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner) : '0;
    assign fifo_data_o = data_i[int'(r_owner)*BITWIDTH +: BITWIDTH];
    assign busy_o      = (r_state == S_GRANT);
    assign owner_o     = r_owner;

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found && w_launch_ok) begin
                    w_state_nxt    = S_GRANT;
                    w_owner_nxt    = w_win;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_accept) w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                if (w_release) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_bpc_fifo_arbiter.sv
// Scoreboard bench for bpc_fifo_arbiter: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_bpc_fifo_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N-1:0]   last_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   gnt_o;
    logic [W-1:0]   fifo_data_o;
    logic           fifo_wr_o;
    logic           fifo_full_i = 1'b0;
    logic           fifo_threshold_i = 1'b0;
    logic           busy_o;
    logic [1:0]     owner_o;

    bpc_fifo_arbiter #(.NUM_REQ(N), .BITWIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .last_i(last_i), .data_i(data_i),
        .gnt_o(gnt_o), .fifo_data_o(fifo_data_o), .fifo_wr_o(fifo_wr_o),
        .fifo_full_i(fifo_full_i), .fifo_threshold_i(fifo_threshold_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic         wr;
        logic [W-1:0] data;
        logic         busy;
        logic [1:0]   owner;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model: which lane holds the port (-1 = none), where the next search starts,
    // beats taken in this burst, and the most recent owner.
    int m_lock = -1, m_ptr = 0, m_beats = 0, m_own = 0;
    bit m_valid = 0;

    function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int lane);
        return d[lane*W +: W];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] ls,
                         input logic full, input logic thr, input logic r);
        exp_t e;
        bit   acc;
        bit   allow;
        @(posedge clk);
        #1;
        cyc++;
        req_i = rq; last_i = ls; fifo_full_i = full; fifo_threshold_i = thr; rst = r;
        for (int i = 0; i < N * W / 32; i++) data_i[i*32 +: 32] = $urandom;
        acc = (m_lock >= 0) && rq[m_lock] && !full;
        if (m_valid) begin
            e.gnt   = acc ? N'(1 << m_lock) : '0;
            e.wr    = acc;
            e.data  = slice(data_i, (m_lock >= 0) ? m_lock : m_own);
            e.busy  = (m_lock >= 0);
            e.owner = 2'(m_own);
            exp_q.push_back(e);
        end
`ifdef BPC_ARB_THROTTLE_EN
        allow = !thr;
`else
        allow = 1;
`endif
        if (r) begin
            m_lock = -1; m_ptr = 0; m_beats = 0; m_own = 0; m_valid = 1;
        end else if (m_lock >= 0) begin
            if (!rq[m_lock]) begin
                m_ptr = (m_lock + 1) % N; m_lock = -1;
            end else if (acc) begin
                m_beats++;
                if (ls[m_lock] || m_beats == MB) begin
                    m_ptr = (m_lock + 1) % N; m_lock = -1;
                end
            end
        end else if (allow) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (rq[c]) begin
                    m_lock = c; m_own = c; m_beats = 0;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnt_o",       W'(gnt_o),     W'(e.gnt));
            chk("fifo_wr_o",   W'(fifo_wr_o), W'(e.wr));
            chk("fifo_data_o", fifo_data_o,   e.data);
            chk("busy_o",      W'(busy_o),    W'(e.busy));
            chk("owner_o",     W'(owner_o),   W'(e.owner));
            if (fifo_wr_o && fifo_full_i) begin
                n_fail++;
                $display("FAIL wr_while_full cycle %0d: got wr=1 expected wr=0", cyc);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        cycle('0, '0, 0, 0, 1);
        cycle('0, '0, 0, 0, 1);
        cycle('0, '0, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        // single lane, 3-beat packet
        cycle(4'b0100, 4'b0000, 0, 0, 0);
        cycle(4'b0100, 4'b0000, 0, 0, 0);
        cycle(4'b0100, 4'b0000, 0, 0, 0);
        cycle(4'b0100, 4'b0100, 0, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0, 0);
        // fairness with 1-beat packets
        for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        // burst cap
        for (int i = 0; i < 24; i++) cycle(4'b0011, 4'b0010, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        // backpressure mid-burst
        for (int i = 0; i < 3; i++) cycle(4'b0001, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(4'b0001, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(4'b0001, 4'b0000, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        // withdraw
        for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0000, 0, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0, 0);
        cycle(4'b1000, 4'b1000, 0, 0, 0);
        cycle(4'b1000, 4'b1000, 0, 0, 0);
        // reset during grant
        cycle(4'b0010, 4'b0000, 0, 0, 0);
        cycle(4'b0010, 4'b0000, 0, 0, 0);
        cycle(4'b0010, 4'b0000, 0, 0, 1);
        cycle(4'b0000, 4'b0000, 0, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0, 0);
        // threshold while lane 1 waits in IDLE
        for (int i = 0; i < 4; i++) cycle(4'b0010, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0010, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        // random traffic with sticky requests
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] ls;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
                ls[b] = ($urandom_range(0, 7) == 0);
            end
            cycle(rq, ls, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
